// File: rtl/fifo_uart_tx_if.sv
// FIFO read-side bundle between a byte FIFO and the UART transmitter.
// master = transmitter (pops), slave = FIFO (supplies data/empty).
interface fifo_uart_tx_if #(
  parameter int DATA_WIDTH = 8
);
  logic [DATA_WIDTH-1:0] fifo_data_in;
  logic                  fifo_empty_in;
  logic                  fifo_read_en_out;

  modport master (
    input  fifo_data_in,
    input  fifo_empty_in,
    output fifo_read_en_out
  );

  modport slave (
    output fifo_data_in,
    output fifo_empty_in,
    input  fifo_read_en_out
  );
endinterface

// File: rtl/fifo_uart_tx.sv
// UART transmitter that pops bytes from a FIFO and sends 8N1-style frames.
// Frame: start bit, DATA_WIDTH bits LSB first, one stop bit.
module fifo_uart_tx #(
  parameter int CLKS_PER_BIT = 434,
  parameter int DATA_WIDTH   = 8
) (
  input  logic          clk,
  input  logic          rst,
  fifo_uart_tx_if.master fifo,
  input  logic          enable_in,
  output logic          tx_out,
  output logic          busy_out,
  output logic          tx_done_out
);

  localparam int BW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int IW = $clog2(DATA_WIDTH);
  localparam logic [BW-1:0] BAUD_MAX = BW'(CLKS_PER_BIT - 1);
  localparam logic [IW-1:0] BIT_MAX  = IW'(DATA_WIDTH - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_START,
    S_DATA,
    S_STOP
  } state_t;

  state_t                r_state;
  logic [BW-1:0]         r_baud;
  logic [IW-1:0]         r_idx;
  logic [DATA_WIDTH-1:0] r_shift;
  logic                  r_tx;

  state_t                w_state_nx;
  logic [BW-1:0]         w_baud_nx;
  logic [IW-1:0]         w_idx_nx;
  logic [DATA_WIDTH-1:0] w_shift_nx;
  logic                  w_tx_nx;
  logic                  w_pop;
  logic                  w_done;
  logic                  w_bit_end;
  logic                  w_cnt;

  assign w_bit_end = (r_baud == BAUD_MAX);

  always_comb begin
    w_state_nx = r_state;
    w_idx_nx   = r_idx;
    w_shift_nx = r_shift;
    w_pop      = 1'b0;
    w_done     = 1'b0;
    w_cnt      = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_idx_nx = '0;
        w_pop    = !fifo.fifo_empty_in && enable_in && !rst;
        if (w_pop) w_state_nx = S_FETCH;
      end
      S_FETCH: begin
        w_shift_nx = fifo.fifo_data_in;
        w_idx_nx   = '0;
        w_state_nx = S_START;
      end
      S_START: begin
        w_cnt = 1'b1;
        if (w_bit_end) w_state_nx = S_DATA;
      end
      S_DATA: begin
        w_cnt = 1'b1;
        if (w_bit_end) begin
          if (r_idx == BIT_MAX) begin
            w_state_nx = S_STOP;
          end else begin
            w_idx_nx   = r_idx + 1'b1;
            w_shift_nx = {1'b0, r_shift[DATA_WIDTH-1:1]};
          end
        end
      end
      S_STOP: begin
        w_cnt  = 1'b1;
        w_done = w_bit_end;
        if (w_bit_end) w_state_nx = S_IDLE;
      end
      default: w_state_nx = S_IDLE;
    endcase

    if (w_state_nx != r_state || w_bit_end || !w_cnt)
      w_baud_nx = '0;
    else
      w_baud_nx = r_baud + 1'b1;

    // Line level is registered from the next state so it lines up with it.
    case (w_state_nx)
      S_START: w_tx_nx = 1'b0;
      S_DATA:  w_tx_nx = w_shift_nx[0];
      default: w_tx_nx = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_baud  <= '0;
      r_idx   <= '0;
      r_shift <= '0;
      r_tx    <= 1'b1;
    end else begin
      r_state <= w_state_nx;
      r_baud  <= w_baud_nx;
      r_idx   <= w_idx_nx;
      r_shift <= w_shift_nx;
      r_tx    <= w_tx_nx;
    end
  end

  assign fifo.fifo_read_en_out = w_pop;
  assign tx_out      = r_tx;
  assign busy_out    = (r_state != S_IDLE);
  assign tx_done_out = w_done && !rst;

endmodule

// File: doc/fifo_uart_tx.md
FIFO_UART_TX -- requirements
Module: fifo_uart_tx

Interface
Parameters:
REQ-001 The block SHALL have parameter CLKS_PER_BIT, default 434, giving clock cycles per serial bit; legal values are >= 2.
REQ-002 The block SHALL have parameter DATA_WIDTH, default 8, giving frame payload bits; legal values are 5 to 8.

Ports:
REQ-003 The block SHALL have port clk, input, 1 bit: single clock; all state changes on its rising edge.
REQ-004 The block SHALL have port rst, input, 1 bit: synchronous active-high reset.
REQ-005 The block SHALL have port fifo_data_in, input, DATA_WIDTH bits: FIFO read data, valid on the cycle after a pop.
REQ-006 The block SHALL have port fifo_empty_in, input, 1 bit: FIFO empty flag.
REQ-007 The block SHALL have port fifo_read_en_out, output, 1 bit: FIFO pop request.
REQ-008 The block SHALL have port enable_in, input, 1 bit: permits fetching new bytes.
REQ-009 The block SHALL have port tx_out, output, 1 bit: serial line, idle high.
REQ-010 The block SHALL have port busy_out, output, 1 bit: high whenever the FSM is not IDLE.
REQ-011 The block SHALL have port tx_done_out, output, 1 bit: one-cycle pulse at the end of each frame.

Function
REQ-012 The FSM SHALL have states IDLE, FETCH, START, DATA and STOP.
REQ-013 fifo_read_en_out SHALL be combinational: high only when state==IDLE, fifo_empty_in==0, enable_in==1 and rst==0.
REQ-014 From IDLE, the FSM SHALL go to FETCH on the edge ending any cycle with fifo_read_en_out=1, and otherwise stay in IDLE.
REQ-015 fifo_read_en_out SHALL be high for exactly one cycle per byte; no pop SHALL occur in any state other than IDLE.
REQ-016 In FETCH, which lasts one cycle, the block SHALL latch fifo_data_in into the shift register and go to START.
REQ-017 tx_out SHALL be a registered output.
REQ-018 tx_out SHALL be 0 for exactly CLKS_PER_BIT cycles in START, starting 2 cycles after the pop cycle.
REQ-019 In DATA, tx_out SHALL send DATA_WIDTH bits LSB first, each held for CLKS_PER_BIT cycles.
REQ-020 A bit index counter SHALL advance once per bit; leaving DATA after bit DATA_WIDTH-1 goes to STOP.
REQ-021 In STOP, tx_out SHALL be 1 for CLKS_PER_BIT cycles; after the last of these the FSM returns to IDLE.
REQ-022 tx_done_out SHALL be 1 only in the final cycle of STOP.
REQ-023 The baud counter SHALL be $clog2(CLKS_PER_BIT) bits wide, count 0..CLKS_PER_BIT-1, wrap to 0 at each bit boundary, and clear on every state entry.
REQ-024 Frame length SHALL be (DATA_WIDTH+2)*CLKS_PER_BIT cycles from the first START cycle to the last STOP cycle.
REQ-025 Back-to-back bytes SHALL be popped (DATA_WIDTH+2)*CLKS_PER_BIT+2 cycles apart, giving a 2-cycle idle-high gap between a stop bit and the next start bit.
REQ-026 Deasserting enable_in mid-frame SHALL NOT abort the frame; it only blocks the next pop.
REQ-027 fifo_empty_in SHALL be ignored outside IDLE.
REQ-028 busy_out SHALL equal (state != IDLE), combinational from the state register.
REQ-029 When fifo_empty_in and enable_in change in the same cycle, only their values in that cycle SHALL be evaluated; there is no look-ahead.

Reset
REQ-030 While rst=1, the block SHALL force state IDLE, tx_out=1, tx_done_out=0, busy_out=0, fifo_read_en_out=0, and clear the baud counter, bit index and shift register on the next edge.
REQ-031 Reset asserted mid-frame SHALL abandon the in-flight byte: tx_out is 1 from the cycle after the reset edge, and no tx_done_out pulse occurs.
REQ-032 Reset asserted in FETCH SHALL discard the already-popped byte, and no further pop SHALL occur until rst is low.

Verification
Bench parameters: CLKS_PER_BIT=4, DATA_WIDTH=8; cycle N is the pop cycle.
REQ-033 Reset scenario: hold rst 3 cycles -> tx_out=1, busy_out=0, fifo_read_en_out=0, tx_done_out=0 throughout, including while fifo_empty_in=0.
REQ-034 Single-byte scenario: FIFO holds 0xA5, enable_in=1 -> read_en high in N only; tx_out=0 in N+2..N+5; bit pattern 1,0,1,0,0,1,0,1 for 4 cycles each in N+6..N+37; tx_out=1 in N+38..N+41; tx_done_out high in N+41 only; busy_out high in N+1..N+41.
REQ-035 Back-to-back scenario: FIFO holds 0x00 then 0xFF -> read_en pulses at N and N+42; tx_out=1 in N+42..N+43; second start bit begins at N+44; two tx_done_out pulses in total.
REQ-036 Empty-FIFO scenario: fifo_empty_in=1 and enable_in=1 for 100 cycles -> read_en never asserted, tx_out stays 1, busy_out stays 0.
REQ-037 Reset mid-frame scenario: assert rst in cycle N+10 during DATA -> tx_out=1 and busy_out=0 from N+11, no tx_done_out; after rst release, the next byte 0x3C is sent intact with the REQ-034 timing.
REQ-038 Enable-drop scenario: drop enable_in at N+20 with 2 bytes queued -> the current frame completes with tx_done_out at N+41, and no further read_en occurs while enable_in=0.
